sensor_qualifier: RTL and testbench

- Front-end conditioning stage directly upstream of the security alarm FSM.
- Takes raw, asynchronous zone sensor lines and synchronises and debounces each one.
- Latches qualified trips per zone and drives the single `sensor` level that the FSM's armed→triggered transition consumes.
- Flags tamper (a chattering line) separately, so a noisy or shorted sensor cannot silently trip or mask the alarm.

---
 rtl/sensor_qualifier.sv | 102 ++++++++++
 tb/tb_sensor_qualifier.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_qualifier.sv
// Zone sensor front end: synchronise, debounce, latch qualified trips and flag chattering lines.
// sensor is the OR of the latched trips and drives the alarm FSM directly.
module sensor_qualifier #(
  parameter int unsigned ZONES         = 4,
  parameter int unsigned DEBOUNCE      = 16,
  parameter int unsigned TAMPER_EDGES  = 8,
  parameter int unsigned TAMPER_WINDOW = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ZONES-1:0] raw_zone,
  input  logic [ZONES-1:0] zone_mask,
  input  logic             clear,
  output logic [ZONES-1:0] zone_state,
  output logic [ZONES-1:0] zone_latched,
  output logic             sensor,
  output logic             trip_pulse,
  output logic             tamper
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE);
  localparam int unsigned EC_W  = $clog2(TAMPER_EDGES + 1);
  localparam int unsigned WIN_W = $clog2(TAMPER_WINDOW);

  logic [ZONES-1:0] r_s1;
  logic [ZONES-1:0] r_s2;
  logic [ZONES-1:0] r_s3;
  logic [DB_W-1:0]  r_db_cnt [ZONES];
  logic [EC_W-1:0]  r_ec_cnt [ZONES];
  logic [WIN_W-1:0] r_win;

  logic [ZONES-1:0] w_zone_edge;
  logic [ZONES-1:0] w_state_nxt;
  logic [ZONES-1:0] w_trip;
  logic [DB_W-1:0]  w_db_nxt [ZONES];
  logic [EC_W-1:0]  w_ec_nxt [ZONES];
  logic             w_wrap;
  logic             w_tamper_hit;

  // Next-state for debounce, tamper edge counters and trip detection
  always_comb begin
    w_zone_edge  = r_s2 ^ r_s3;
    w_wrap       = (r_win == WIN_W'(TAMPER_WINDOW - 1));
    w_state_nxt  = zone_state;
    w_tamper_hit = 1'b0;
    for (int i = 0; i < int'(ZONES); i++) begin
      w_db_nxt[i] = '0;
      w_ec_nxt[i] = r_ec_cnt[i];
      if (r_s2[i] != zone_state[i]) begin
        if (r_db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          w_state_nxt[i] = r_s2[i];
        end else begin
          w_db_nxt[i] = r_db_cnt[i] + DB_W'(1);
        end
      end
      // An edge on the wrap cycle is the first edge of the new window
      if (w_wrap) begin
        w_ec_nxt[i] = EC_W'(w_zone_edge[i]);
      end else if (w_zone_edge[i] && (r_ec_cnt[i] != EC_W'(TAMPER_EDGES))) begin
        w_ec_nxt[i] = r_ec_cnt[i] + EC_W'(1);
        if (w_ec_nxt[i] == EC_W'(TAMPER_EDGES)) begin
          w_tamper_hit = 1'b1;
        end
      end
    end
    w_trip = ~zone_state & w_state_nxt & zone_mask;
  end

  // State registers; trip and tamper set take priority over clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_s3         <= '0;
      r_win        <= '0;
      zone_state   <= '0;
      zone_latched <= '0;
      trip_pulse   <= 1'b0;
      tamper       <= 1'b0;
      for (int i = 0; i < int'(ZONES); i++) begin
        r_db_cnt[i] <= '0;
        r_ec_cnt[i] <= '0;
      end
    end else begin
      r_s1         <= raw_zone;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_win        <= w_wrap ? '0 : r_win + WIN_W'(1);
      zone_state   <= w_state_nxt;
      zone_latched <= (clear ? '0 : zone_latched) | w_trip;
      trip_pulse   <= |w_trip;
      tamper       <= (tamper & ~clear) | w_tamper_hit;
      for (int i = 0; i < int'(ZONES); i++) begin
        r_db_cnt[i] <= w_db_nxt[i];
        r_ec_cnt[i] <= w_ec_nxt[i];
      end
    end
  end

  assign sensor = |zone_latched;

endmodule

// File: tb/tb_sensor_qualifier.sv
// Directed bench for sensor_qualifier (ZONES=4, DEBOUNCE=4, TAMPER_EDGES=3, TAMPER_WINDOW=32).
module tb_sensor_qualifier;

  logic       clk;
  logic       rst;
  logic [3:0] raw_zone;
  logic [3:0] zone_mask;
  logic       clear;
  logic [3:0] zone_state;
  logic [3:0] zone_latched;
  logic       sensor;
  logic       trip_pulse;
  logic       tamper;

  int checks;
  int errors;

  sensor_qualifier #(
    .ZONES(4), .DEBOUNCE(4), .TAMPER_EDGES(3), .TAMPER_WINDOW(32)
  ) dut (
    .clk(clk), .rst(rst), .raw_zone(raw_zone), .zone_mask(zone_mask),
    .clear(clear), .zone_state(zone_state), .zone_latched(zone_latched),
    .sensor(sensor), .trip_pulse(trip_pulse), .tamper(tamper)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge; inputs driven and outputs sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_state"},   32'(zone_state),   32'h0);
    check_eq({tag, "_latched"}, 32'(zone_latched), 32'h0);
    check_eq({tag, "_sensor"},  32'(sensor),       32'h0);
    check_eq({tag, "_trip"},    32'(trip_pulse),   32'h0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    raw_zone  = 4'h0;
    zone_mask = 4'hF;
    clear     = 1'b0;
    step();
    step();
    rst = 1'b0;

    check_quiet("reset");
    check_eq("reset_tamper", 32'(tamper), 32'h0);

    // Glitch shorter than the debounce period never qualifies
    raw_zone = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step();
      check_quiet("glitch_hi");
    end
    raw_zone = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      step();
      check_quiet("glitch_lo");
    end

    // Stable trip on zone 1: qualifies on the 6th edge
    do_reset();
    raw_zone = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_quiet("trip_wait");
    end
    step();
    check_eq("trip_state",   32'(zone_state),   32'h2);
    check_eq("trip_latched", 32'(zone_latched), 32'h2);
    check_eq("trip_sensor",  32'(sensor),       32'h1);
    check_eq("trip_pulse",   32'(trip_pulse),   32'h1);
    step();
    check_eq("trip_pulse_end", 32'(trip_pulse), 32'h0);
    raw_zone = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_eq("fall_state",   32'(zone_state),   (k >= 6) ? 32'h0 : 32'h2);
      check_eq("fall_latched", 32'(zone_latched), 32'h2);
      check_eq("fall_sensor",  32'(sensor),       32'h1);
      check_eq("fall_trip",    32'(trip_pulse),   32'h0);
    end

    // Masked zone debounces but never latches, even once unmasked
    do_reset();
    zone_mask = 4'b1011;
    raw_zone  = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_eq("mask_trip", 32'(trip_pulse), 32'h0);
    end
    check_eq("mask_state",   32'(zone_state),   32'h4);
    check_eq("mask_latched", 32'(zone_latched), 32'h0);
    zone_mask = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("unmask_latched", 32'(zone_latched), 32'h0);
      check_eq("unmask_trip",    32'(trip_pulse),   32'h0);
    end
    check_eq("unmask_sensor", 32'(sensor), 32'h0);

    // Clear coinciding with a zone 0 trip: the new trip survives
    do_reset();
    raw_zone = 4'b0010;
    for (int k = 0; k < 6; k++) step();
    check_eq("coll_pre_latched", 32'(zone_latched), 32'h2);
    step();
    raw_zone = 4'b0011;
    for (int k = 0; k < 5; k++) step();
    check_eq("coll_pre_state", 32'(zone_state), 32'h2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("coll_state",   32'(zone_state),   32'h3);
    check_eq("coll_latched", 32'(zone_latched), 32'h1);
    check_eq("coll_sensor",  32'(sensor),       32'h1);
    check_eq("coll_trip",    32'(trip_pulse),   32'h1);
    step();
    check_eq("coll_trip_end", 32'(trip_pulse),   32'h0);
    check_eq("coll_latched2", 32'(zone_latched), 32'h1);

    // Chatter on zone 3: third counted transition raises tamper
    do_reset();
    raw_zone = 4'b1000;
    for (int k = 1; k <= 7; k++) begin
      step();
      check_eq("tamp_flag",  32'(tamper),        (k == 7) ? 32'h1 : 32'h0);
      check_eq("tamp_state", 32'(zone_state[3]), 32'h0);
      if (k % 2 == 0) raw_zone[3] = ~raw_zone[3];
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("tamp_clear", 32'(tamper), 32'h0);
    for (int k = 0; k < 20; k++) begin
      step();
      check_eq("tamp_stay",    32'(tamper),       32'h0);
      check_eq("tamp_latched", 32'(zone_latched), 32'h0);
    end

    // Reset during debounce discards the partial count
    do_reset();
    raw_zone = 4'b0001;
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_quiet("midrst");
    check_eq("midrst_tamper", 32'(tamper), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_eq("midrst_wait", 32'(zone_state), 32'h0);
    end
    step();
    check_eq("midrst_state", 32'(zone_state), 32'h1);
    check_eq("midrst_trip",  32'(trip_pulse), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
